core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/seq_pkg.sv | 25 ++
 rtl/sat_counter.sv | 35 +++
 rtl/core_sequencer.sv | 172 +++++++++++++++++
 tb/tb_core_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default sizing for the core load/run/drain sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CRST,
      ST_RUN,
      ST_DRAIN,
      ST_FIN
   } seq_state_e;

   localparam int DEF_LOAD_BASE  = 0;
   localparam int DEF_LOAD_LEN   = 4;
   localparam int DEF_DRAIN_BASE = 32;
   localparam int DEF_DRAIN_LEN  = 2;
   localparam int DEF_MAX_CYC    = 1000;
   localparam int CYC_W          = 16;

   // Memory addresses wrap modulo 256.
   function automatic logic [7:0] addr_add(input int base, input logic [7:0] idx);
      return 8'(base) + idx;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over en.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // Next count: clear, hold at saturation, or increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/core_sequencer.sv
// Loads a program/data image into memory, runs the core, then drains results.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for req; core held in reset, sequencer owns memory
//   LOAD     | accepting LOAD_LEN bytes into memory at LOAD_BASE+idx
//   CRST     | one-cycle core reset pulse; clears cyc_cnt and timeout
//   RUN      | core owns memory and runs until core_done or MAX_CYC
//   DRAIN    | streaming DRAIN_LEN bytes out from DRAIN_BASE+idx
//   FIN      | results held, done=1, waits for req to drop
module core_sequencer
   import seq_pkg::*;
#(
   parameter int LOAD_BASE  = DEF_LOAD_BASE,
   parameter int LOAD_LEN   = DEF_LOAD_LEN,
   parameter int DRAIN_BASE = DEF_DRAIN_BASE,
   parameter int DRAIN_LEN  = DEF_DRAIN_LEN,
   parameter int MAX_CYC    = DEF_MAX_CYC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_own,
   output logic        mem_wr_en,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wr_dat,
   input  logic [7:0]  mem_rd_dat,
   output logic        core_reset,
   input  logic        core_done,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [15:0] cyc_cnt
);

   localparam logic [7:0]  LOAD_LAST  = 8'(LOAD_LEN - 1);
   localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_LEN - 1);
   // The run ends on the edge where cyc_cnt becomes MAX_CYC-1.
   localparam logic [31:0] RUN_LIMIT  = 32'(MAX_CYC - 1);

   seq_state_e       state_q, state_d;
   logic [7:0]       idx_q, idx_d;
   logic             timeout_q, timeout_d;
   logic [CYC_W-1:0] cyc_cnt_w;
   logic             limit_hit;

   sat_counter #(.W(CYC_W)) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q == ST_CRST),
      .en    (state_q == ST_RUN),
      .count (cyc_cnt_w)
   );

   assign limit_hit = (({16'd0, cyc_cnt_w} + 32'd1) >= RUN_LIMIT);

   // Output decode from state and idx.
   always_comb begin
      in_ready   = 1'b0;
      mem_own    = 1'b1;
      mem_wr_en  = 1'b0;
      mem_addr   = 8'd0;
      mem_wr_dat = 8'd0;
      core_reset = 1'b1;
      out_valid  = 1'b0;
      out_data   = 8'd0;
      busy       = 1'b1;
      done       = 1'b0;
      unique case (state_q)
         ST_IDLE: busy = 1'b0;
         ST_LOAD: begin
            in_ready   = 1'b1;
            mem_wr_en  = in_valid;
            mem_addr   = addr_add(LOAD_BASE, idx_q);
            mem_wr_dat = in_data;
         end
         ST_CRST: ;
         ST_RUN: begin
            mem_own    = 1'b0;
            core_reset = 1'b0;
         end
         ST_DRAIN: begin
            out_valid = 1'b1;
            mem_addr  = addr_add(DRAIN_BASE, idx_q);
            out_data  = mem_rd_dat;
         end
         ST_FIN: begin
            busy = 1'b0;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Next-state, transfer index and sticky timeout.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      timeout_d = timeout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               idx_d   = 8'd0;
               state_d = (LOAD_LEN == 0) ? ST_CRST : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               if (idx_q == LOAD_LAST) begin
                  idx_d   = 8'd0;
                  state_d = ST_CRST;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         ST_CRST: begin
            timeout_d = 1'b0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            idx_d = 8'd0;
            if (core_done || limit_hit) begin
               state_d = (DRAIN_LEN == 0) ? ST_FIN : ST_DRAIN;
            end
            // A completion seen on the limit cycle is not a timeout.
            if (!core_done && limit_hit) begin
               timeout_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (idx_q == DRAIN_LAST) begin
                  idx_d   = 8'd0;
                  state_d = ST_FIN;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         ST_FIN: begin
            if (!req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
   assign cyc_cnt = cyc_cnt_w;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: scenario table plus reset/handshake sequences.
module tb_core_sequencer;

   logic        clk, reset, req;
   logic        in_valid, in_ready;
   logic [7:0]  in_data;
   logic        mem_own, mem_wr_en;
   logic [7:0]  mem_addr, mem_wr_dat, mem_rd_dat;
   logic        core_reset, core_done;
   logic        out_valid, out_ready;
   logic [7:0]  out_data;
   logic        busy, done, timeout;
   logic [15:0] cyc_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [256];
   logic [7:0]  core_out [2];
   logic [15:0] wr_q[$];
   logic [15:0] out_q[$];
   logic [15:0] mon_e;

   typedef struct {
      string          name;
      logic [3:0][7:0] b;
      logic [3:0]     vpat;
      int             done_at;
      int             stall;
      int             exp_cyc;
      logic           exp_to;
   } scen_t;

   scen_t tbl[6];

   core_sequencer #(
      .LOAD_BASE  (0),
      .LOAD_LEN   (4),
      .DRAIN_BASE (32),
      .DRAIN_LEN  (2),
      .MAX_CYC    (100)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_own    (mem_own),
      .mem_wr_en  (mem_wr_en),
      .mem_addr   (mem_addr),
      .mem_wr_dat (mem_wr_dat),
      .mem_rd_dat (mem_rd_dat),
      .core_reset (core_reset),
      .core_done  (core_done),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .cyc_cnt    (cyc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: the core's results live at 32/33, everything else is RAM.
   assign mem_rd_dat = (mem_addr == 8'd32) ? core_out[0] :
                       (mem_addr == 8'd33) ? core_out[1] : mem[mem_addr];

   always @(posedge clk) begin
      if (!reset && mem_own && mem_wr_en) mem[mem_addr] <= mem_wr_dat;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: memory writes and drain handshakes.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_wr_en) begin
            if (wr_q.size() == 0) chk("unexpected_write", 32'(wr_q.size()), 1);
            else begin
               mon_e = wr_q.pop_front();
               chk("load_write", {16'd0, mem_addr, mem_wr_dat}, {16'd0, mon_e});
               chk("load_own", mem_own, 1);
            end
         end
         if (out_valid && out_ready) begin
            if (out_q.size() == 0) chk("unexpected_drain", 32'(out_q.size()), 1);
            else begin
               mon_e = out_q.pop_front();
               chk("drain_byte", {16'd0, mem_addr, out_data}, {16'd0, mon_e});
            end
         end
      end
   end

   task automatic run_scen(input scen_t s);
      logic [7:0] e0, e1;
      int k, st;
      bit fin;
      e0 = s.b[0] + s.b[1];
      e1 = s.b[2] ^ s.b[3];
      req = 1'b1;
      @(posedge clk); #1;
      chk({s.name, "_load_busy"}, busy, 1);
      chk({s.name, "_load_ready"}, in_ready, 1);
      k = 0;
      for (int c = 0; c < 16 && k < 4; c++) begin
         in_valid = s.vpat[c % 4];
         if (in_valid) begin
            in_data = s.b[k];
            wr_q.push_back({8'(k), s.b[k]});
            k++;
         end else begin
            chk({s.name, "_load_idle_ready"}, in_ready, 1);
         end
         @(posedge clk); #1;
      end
      // Offer a fifth byte during CRST; it must not be taken.
      in_valid = 1'b1;
      in_data  = 8'hEE;
      chk({s.name, "_crst_core_reset"}, core_reset, 1);
      chk({s.name, "_crst_in_ready"}, in_ready, 0);
      chk({s.name, "_crst_busy"}, busy, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({s.name, "_run_core_reset"}, core_reset, 0);
      chk({s.name, "_run_mem_own"}, mem_own, 0);
      chk({s.name, "_run_cyc_clr"}, cyc_cnt, 0);
      chk({s.name, "_run_to_clr"}, timeout, 0);
      chk({s.name, "_load_all_written"}, 32'(wr_q.size()), 0);
      core_out[0] = mem[0] + mem[1];
      core_out[1] = mem[2] ^ mem[3];
      out_q.push_back({8'd32, e0});
      out_q.push_back({8'd33, e1});
      if (s.done_at > 0) begin
         for (int j = 1; j < s.done_at; j++) begin
            @(posedge clk); #1;
         end
         core_done = 1'b1;
         @(posedge clk); #1;
         core_done = 1'b0;
      end
      st  = s.stall;
      fin = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         if (done) fin = 1'b1;
         else begin
            if (out_valid && st > 0) begin
               chk({s.name, "_stall_data"}, out_data, e0);
               chk({s.name, "_stall_addr"}, mem_addr, 32);
               out_ready = 1'b0;
               st--;
            end else begin
               out_ready = 1'b1;
            end
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      chk({s.name, "_reach_fin"}, done, 1);
      chk({s.name, "_cyc_cnt"}, cyc_cnt, s.exp_cyc);
      chk({s.name, "_timeout"}, timeout, s.exp_to);
      chk({s.name, "_drain_all"}, 32'(out_q.size()), 0);
      chk({s.name, "_fin_busy"}, busy, 0);
      chk({s.name, "_fin_out_valid"}, out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk({s.name, "_hold_done"}, done, 1);
         chk({s.name, "_hold_core_reset"}, core_reset, 1);
         chk({s.name, "_hold_cyc"}, cyc_cnt, s.exp_cyc);
         chk({s.name, "_hold_to"}, timeout, s.exp_to);
      end
      req = 1'b0;
      @(posedge clk); #1;
      chk({s.name, "_idle_done"}, done, 0);
      chk({s.name, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{name:"normal",   b:32'h44332211, vpat:4'b1111, done_at:40, stall:0, exp_cyc:40, exp_to:1'b0};
      tbl[1] = '{name:"backpr",   b:32'hD4C3B2A1, vpat:4'b0101, done_at:10, stall:3, exp_cyc:10, exp_to:1'b0};
      tbl[2] = '{name:"timeout",  b:32'h0F0E0D0C, vpat:4'b1111, done_at:0,  stall:1, exp_cyc:99, exp_to:1'b1};
      tbl[3] = '{name:"coincide", b:32'h88776655, vpat:4'b1011, done_at:99, stall:0, exp_cyc:99, exp_to:1'b0};
      tbl[4] = '{name:"before",   b:32'h01020304, vpat:4'b1111, done_at:98, stall:0, exp_cyc:98, exp_to:1'b0};
      tbl[5] = '{name:"first",    b:32'hF0E0D0C0, vpat:4'b1111, done_at:1,  stall:2, exp_cyc:1,  exp_to:1'b0};

      reset = 1'b1; req = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      core_done = 1'b0; out_ready = 1'b1;
      core_out[0] = 8'd0; core_out[1] = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_mem_own", mem_own, 1);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_cyc_cnt", cyc_cnt, 0);
      chk("rst_timeout", timeout, 0);

      foreach (tbl[i]) run_scen(tbl[i]);

      // Reset in the middle of a load.
      req = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h5A + 8'(i);
         wr_q.push_back({8'(i), 8'h5A + 8'(i)});
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = 8'hC3;
      reset    = 1'b1;
      req      = 1'b0;
      @(posedge clk); #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("midload_in_ready", in_ready, 0);
      chk("midload_core_reset", core_reset, 1);
      chk("midload_busy", busy, 0);
      chk("midload_mem_own", mem_own, 1);
      chk("midload_written", 32'(wr_q.size()), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("midload_stays_idle", busy, 0);
      run_scen(tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
